// File: rtl/wb_sweep_pkg.sv
// Shared types for the Wishbone sweep master: FSM state encoding and status field width.
package wb_sweep_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR     = 3'd1,
      WR_ACK = 3'd2,
      GAP    = 3'd3,
      RD     = 3'd4,
      RD_ACK = 3'd5,
      DONE   = 3'd6
   } sweep_state_e;

   localparam int STATUS_W = 4;

   // States in which a bus transaction is outstanding and the watchdog runs.
   function automatic logic is_txn(input sweep_state_e s);
      return (s == WR) || (s == WR_ACK) || (s == RD) || (s == RD_ACK);
   endfunction

endpackage

// File: rtl/wb_sweep_master_edge_detect.sv
// Registered rising-edge detector; the history flop resets low so a level held
// high through reset is seen as a fresh edge.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic level_r;
   logic pulse_r;

   // History flop and registered edge pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_r <= 1'b0;
         pulse_r <= 1'b0;
      end else begin
         level_r <= level;
         pulse_r <= level & ~level_r;
      end
   end

   assign pulse = pulse_r;

endmodule

// File: rtl/wb_sweep_master.sv
// Pipelined Wishbone master: one start write per trigger edge, then status polls
// until the sweep slave reports idle; flags completion, drops and timeouts.
module wb_sweep_master
   import wb_sweep_pkg::*;
#(
   parameter logic [31:0] WB_ADDR    = 32'h0000_0000,
   parameter logic [31:0] START_DATA = 32'h0000_0001,
   parameter logic [31:0] POLL_GAP   = 32'd4,
   parameter logic [31:0] TIMEOUT    = 32'd4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trigger,
   input  logic        clear_err,
   output logic [31:0] wb_addr,
   output logic [31:0] wb_data_w,
   input  logic [31:0] wb_data_r,
   output logic        wb_we,
   output logic        wb_stb,
   output logic        wb_cyc,
   input  logic        wb_ack,
   input  logic        wb_stall,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  done_count,
   output logic [7:0]  dropped
);

   sweep_state_e state_r, state_s;
   logic [31:0]  addr_r, data_w_r, data_w_s;
   logic         cyc_r, cyc_s, stb_r, stb_s, we_r, we_s;
   logic         busy_r, done_r, err_r, err_s;
   logic [7:0]   done_count_r, done_count_s, dropped_r, dropped_s;
   logic [31:0]  gap_cnt_r, gap_cnt_s, timer_r, timer_s;
   logic         edge_s, accept_s, timeout_s;
   logic         unused_rdata_s;

   edge_detect u_edge (
      .clk   (clk),
      .rst   (rst),
      .level (trigger),
      .pulse (edge_s)
   );

   // Only the status nibble carries meaning on reads.
   assign unused_rdata_s = ^wb_data_r[31:STATUS_W];

   // Next-state and next-output decode for the sweep FSM and its counters.
   always_comb begin
      state_s      = state_r;
      cyc_s        = cyc_r;
      stb_s        = stb_r;
      we_s         = we_r;
      data_w_s     = data_w_r;
      gap_cnt_s    = 32'd0;
      timer_s      = timer_r + 32'd1;
      accept_s     = edge_s && (state_r == IDLE) && !err_r;
      timeout_s    = is_txn(state_r) && (timer_r >= (TIMEOUT - 32'd1));

      if (timeout_s) begin
         state_s = IDLE;
         cyc_s   = 1'b0;
         stb_s   = 1'b0;
         we_s    = 1'b0;
         timer_s = 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               timer_s = 32'd0;
               if (accept_s) begin
                  state_s  = WR;
                  cyc_s    = 1'b1;
                  stb_s    = 1'b1;
                  we_s     = 1'b1;
                  data_w_s = START_DATA;
               end else begin
                  state_s = IDLE;
               end
            end
            WR: begin
               if (!wb_stall) begin
                  state_s = WR_ACK;
                  stb_s   = 1'b0;
               end else begin
                  state_s = WR;
               end
            end
            WR_ACK: begin
               if (wb_ack) begin
                  state_s = GAP;
                  cyc_s   = 1'b0;
                  we_s    = 1'b0;
               end else begin
                  state_s = WR_ACK;
               end
            end
            GAP: begin
               timer_s = 32'd0;
               if (gap_cnt_r >= (POLL_GAP - 32'd1)) begin
                  state_s = RD;
                  cyc_s   = 1'b1;
                  stb_s   = 1'b1;
                  we_s    = 1'b0;
               end else begin
                  gap_cnt_s = gap_cnt_r + 32'd1;
               end
            end
            RD: begin
               if (!wb_stall) begin
                  state_s = RD_ACK;
                  stb_s   = 1'b0;
               end else begin
                  state_s = RD;
               end
            end
            RD_ACK: begin
               if (wb_ack) begin
                  cyc_s   = 1'b0;
                  state_s = (wb_data_r[STATUS_W-1:0] == 4'd0) ? DONE : GAP;
               end else begin
                  state_s = RD_ACK;
               end
            end
            DONE: begin
               timer_s = 32'd0;
               state_s = IDLE;
            end
            default: begin
               state_s = IDLE;
               cyc_s   = 1'b0;
               stb_s   = 1'b0;
               we_s    = 1'b0;
               timer_s = 32'd0;
            end
         endcase
      end

      // A timeout outranks a simultaneous clear so the fault is never lost.
      if (timeout_s) begin
         err_s = 1'b1;
      end else if (clear_err) begin
         err_s = 1'b0;
      end else begin
         err_s = err_r;
      end

      if (edge_s && !accept_s && (dropped_r != 8'hFF)) begin
         dropped_s = dropped_r + 8'd1;
      end else begin
         dropped_s = dropped_r;
      end

      if (state_s == DONE) begin
         done_count_s = done_count_r + 8'd1;
      end else begin
         done_count_s = done_count_r;
      end
   end

   // State, bus output and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         addr_r       <= WB_ADDR;
         data_w_r     <= 32'h0000_0000;
         cyc_r        <= 1'b0;
         stb_r        <= 1'b0;
         we_r         <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
         done_count_r <= 8'd0;
         dropped_r    <= 8'd0;
         gap_cnt_r    <= 32'd0;
         timer_r      <= 32'd0;
      end else begin
         state_r      <= state_s;
         addr_r       <= WB_ADDR;
         data_w_r     <= data_w_s;
         cyc_r        <= cyc_s;
         stb_r        <= stb_s;
         we_r         <= we_s;
         busy_r       <= (state_s != IDLE);
         done_r       <= (state_s == DONE);
         err_r        <= err_s;
         done_count_r <= done_count_s;
         dropped_r    <= dropped_s;
         gap_cnt_r    <= gap_cnt_s;
         timer_r      <= timer_s;
      end
   end

   assign wb_addr    = addr_r;
   assign wb_data_w  = data_w_r;
   assign wb_we      = we_r;
   assign wb_stb     = stb_r;
   assign wb_cyc     = cyc_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign err        = err_r;
   assign done_count = done_count_r;
   assign dropped    = dropped_r;

endmodule

// File: tb/tb_wb_sweep_master.sv
// Bench for wb_sweep_master: a behavioural sweep slave answers instance A; instance B
// (short watchdog) exercises timeout, sticky error and recovery.
module tb_wb_sweep_master;

   localparam logic [31:0] P_ADDR  = 32'h0000_0000;
   localparam logic [31:0] P_START = 32'h0000_0001;
   localparam int          P_GAP   = 4;
   localparam int          P_TO_B  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // instance A signals
   logic        trig_a = 1'b0, clr_a = 1'b0;
   logic [31:0] a_addr, a_dw, a_dr;
   logic        a_we, a_stb, a_cyc, a_ack, a_stall, a_busy, a_done, a_err;
   logic [7:0]  a_dc, a_dp;

   // instance B signals
   logic        trig_b = 1'b0, clr_b = 1'b0;
   logic [31:0] b_addr, b_dw, b_dr;
   logic        b_we, b_stb, b_cyc, b_ack, b_stall, b_busy, b_done, b_err;
   logic [7:0]  b_dc, b_dp;

   // slave model configuration (written by tasks only)
   int         wr_stall_cfg = 0;
   int         anim_cfg     = 0;
   bit         hold_rd_ack  = 1'b0;
   logic [3:0] script_arr [8];
   int         script_len   = 0;
   bit         ack_b_mode   = 1'b0;

   // slave model state (written by the slave process only)
   int wr_stall_used = 0, anim_left = 0, rd_idx = 0, wr_acc = 0, rd_acc = 0;

   int total = 0, bad = 0;
   logic [7:0] model_dc = 8'd0;

   wb_sweep_master dut_a (
      .clk(clk), .rst(rst), .trigger(trig_a), .clear_err(clr_a),
      .wb_addr(a_addr), .wb_data_w(a_dw), .wb_data_r(a_dr), .wb_we(a_we),
      .wb_stb(a_stb), .wb_cyc(a_cyc), .wb_ack(a_ack), .wb_stall(a_stall),
      .busy(a_busy), .done(a_done), .err(a_err), .done_count(a_dc), .dropped(a_dp)
   );

   wb_sweep_master #(.TIMEOUT(32'd16)) dut_b (
      .clk(clk), .rst(rst), .trigger(trig_b), .clear_err(clr_b),
      .wb_addr(b_addr), .wb_data_w(b_dw), .wb_data_r(b_dr), .wb_we(b_we),
      .wb_stb(b_stb), .wb_cyc(b_cyc), .wb_ack(b_ack), .wb_stall(b_stall),
      .busy(b_busy), .done(b_done), .err(b_err), .done_count(b_dc), .dropped(b_dp)
   );

   // Sweep slave: stalls the write a configurable number of cycles, stalls reads while
   // animating, acks one cycle after acceptance, read status comes from a script.
   assign a_stall = a_cyc && a_stb &&
                    ((a_we && (wr_stall_used < wr_stall_cfg)) || (!a_we && (anim_left > 0)));

   always @(posedge clk) begin
      if (rst) begin
         a_ack <= 1'b0; a_dr <= 32'h0; wr_stall_used <= 0; anim_left <= 0; rd_idx <= 0;
      end else begin
         a_ack <= 1'b0;
         if (a_cyc && a_stb && a_we && a_stall) wr_stall_used <= wr_stall_used + 1;
         else if (!a_stb) wr_stall_used <= 0;
         if (a_cyc && a_stb && !a_stall) begin
            if (a_we) begin
               a_ack     <= 1'b1;
               anim_left <= anim_cfg;
               rd_idx    <= 0;
               wr_acc    <= wr_acc + 1;
            end else begin
               a_ack  <= !hold_rd_ack;
               a_dr   <= {28'hA5A5A5A, (rd_idx < script_len) ? script_arr[rd_idx] : 4'h0};
               rd_idx <= rd_idx + 1;
               rd_acc <= rd_acc + 1;
            end
         end else if (anim_left > 0) begin
            anim_left <= anim_left - 1;
         end
      end
   end

   // Instance B slave: never stalls, status always idle, acks only when enabled.
   assign b_stall = 1'b0;
   assign b_dr    = 32'h0000_0000;
   always @(posedge clk) begin
      if (rst) b_ack <= 1'b0;
      else     b_ack <= ack_b_mode && b_cyc && b_stb;
   end

   task automatic run_until_idle(input int budget, output int dones, output int gaps,
                                 output int gap_bad, output bit timed_out);
      int run;
      bit seen;
      dones = 0; gaps = 0; gap_bad = 0; run = 0; seen = 1'b0; timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (a_done) dones++;
         if (a_busy) seen = 1'b1;
         if (a_busy && !a_cyc) run++;
         else if (a_cyc && run > 0) begin
            gaps++;
            if (run != P_GAP) gap_bad++;
            run = 0;
         end else run = 0;
         if (seen && !a_busy) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({a_cyc, a_stb, a_we, a_busy, a_done, a_err} !== 6'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b want=000000", {a_cyc, a_stb, a_we, a_busy, a_done, a_err});
      end
      total++;
      if (a_addr !== P_ADDR || a_dw !== 32'h0) begin
         bad++; $display("FAIL reset_bus addr=%h data_w=%h want %h/0", a_addr, a_dw, P_ADDR);
      end
      total++;
      if (a_dc !== 8'd0 || a_dp !== 8'd0) begin
         bad++; $display("FAIL reset_counts done_count=%0d dropped=%0d want 0/0", a_dc, a_dp);
      end
      rst = 1'b0;
      model_dc = 8'd0;
      repeat (2) @(negedge clk);
      total++;
      if ({a_cyc, a_busy, b_cyc, b_busy, b_err} !== 5'b0) begin
         bad++; $display("FAIL reset_idle got=%b want=00000", {a_cyc, a_busy, b_cyc, b_busy, b_err});
      end
   endtask

   task automatic test_basic_sweep();
      int d, g, gb, w0, r0;
      bit to;
      anim_cfg = 32; wr_stall_cfg = 0; script_len = 0;
      w0 = wr_acc; r0 = rd_acc;
      trig_a = 1'b1;
      run_until_idle(500, d, g, gb, to);
      trig_a = 1'b0;
      model_dc = model_dc + 8'd1;
      total++;
      if (to || d != 1) begin bad++; $display("FAIL basic_done timed_out=%0d pulses=%0d want 0/1", to, d); end
      total++;
      if (a_dc !== model_dc) begin bad++; $display("FAIL basic_count got=%0d want=%0d", a_dc, model_dc); end
      total++;
      if (wr_acc - w0 != 1 || rd_acc - r0 != 1) begin
         bad++; $display("FAIL basic_txns writes=%0d reads=%0d want 1/1", wr_acc - w0, rd_acc - r0);
      end
      total++;
      if (a_busy !== 1'b0 || a_err !== 1'b0) begin bad++; $display("FAIL basic_idle busy=%b err=%b want 0/0", a_busy, a_err); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write_stall();
      int d, g, gb, n;
      bit to;
      anim_cfg = 0; wr_stall_cfg = 5; script_len = 0;
      trig_a = 1'b1;
      n = 0;
      while (!a_stb && n < 20) begin @(negedge clk); n++; end
      total++;
      if (!a_stb) begin bad++; $display("FAIL stall_start stb=%b want=1", a_stb); end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (a_stall !== 1'b1 || a_stb !== 1'b1 || a_we !== 1'b1 || a_addr !== P_ADDR || a_dw !== P_START) begin
            bad++; $display("FAIL stall_hold cyc%0d stall=%b stb=%b we=%b addr=%h data=%h want 1/1/1/%h/%h",
                            i, a_stall, a_stb, a_we, a_addr, a_dw, P_ADDR, P_START);
         end
         @(negedge clk);
      end
      total++;
      if (a_stall !== 1'b0 || a_stb !== 1'b1) begin bad++; $display("FAIL stall_release stall=%b stb=%b want 0/1", a_stall, a_stb); end
      @(negedge clk);
      total++;
      if (a_stb !== 1'b0 || a_cyc !== 1'b1) begin bad++; $display("FAIL stall_stb_drop stb=%b cyc=%b want 0/1", a_stb, a_cyc); end
      run_until_idle(200, d, g, gb, to);
      trig_a = 1'b0; wr_stall_cfg = 0;
      model_dc = model_dc + 8'd1;
      total++;
      if (to || d != 1 || a_dc !== model_dc) begin
         bad++; $display("FAIL stall_done timed_out=%0d pulses=%0d count=%0d want 0/1/%0d", to, d, a_dc, model_dc);
      end
      repeat (2) @(negedge clk);
   endtask

   // Scripted polls: n busy reads then idle => n+1 reads, each preceded by P_GAP idle cycles.
   task automatic run_scripted(input string tag, input int n, input int wstall);
      int d, g, gb, r0;
      bit to;
      for (int j = 0; j < n; j++) script_arr[j] = 4'($urandom_range(1, 15));
      script_arr[n] = 4'd0;
      script_len = n + 1; anim_cfg = 0; wr_stall_cfg = wstall;
      r0 = rd_acc;
      trig_a = 1'b1;
      run_until_idle(400, d, g, gb, to);
      trig_a = 1'b0; wr_stall_cfg = 0;
      model_dc = model_dc + 8'd1;
      total++;
      if (to || d != 1) begin bad++; $display("FAIL %s_done timed_out=%0d pulses=%0d want 0/1", tag, to, d); end
      total++;
      if (rd_acc - r0 != n + 1) begin bad++; $display("FAIL %s_reads got=%0d want=%0d", tag, rd_acc - r0, n + 1); end
      total++;
      if (g != n + 1 || gb != 0) begin bad++; $display("FAIL %s_gaps count=%0d wrong_len=%0d want %0d/0", tag, g, gb, n + 1); end
      total++;
      if (a_dc !== model_dc) begin bad++; $display("FAIL %s_count got=%0d want=%0d", tag, a_dc, model_dc); end
      repeat ($urandom_range(2, 5)) @(negedge clk);
   endtask

   task automatic test_poll_gap();
      run_scripted("poll", 2, 0);
   endtask

   task automatic test_random_sweeps();
      for (int k = 0; k < 4; k++) run_scripted("rand", $urandom_range(0, 3), $urandom_range(0, 3));
   endtask

   task automatic test_reset_mid();
      int n, d;
      hold_rd_ack = 1'b1; script_len = 0; anim_cfg = 0;
      trig_a = 1'b1;
      n = 0;
      while (!(a_cyc && !a_stb && !a_we) && n < 50) begin @(negedge clk); n++; end
      total++;
      if (!(a_cyc && !a_stb && !a_we)) begin bad++; $display("FAIL midrst_reach cyc=%b stb=%b we=%b want 1/0/0", a_cyc, a_stb, a_we); end
      rst = 1'b1; trig_a = 1'b0;
      @(negedge clk);
      rst = 1'b0; hold_rd_ack = 1'b0;
      model_dc = 8'd0;
      total++;
      if ({a_cyc, a_stb, a_we, a_busy, a_done} !== 5'b0) begin
         bad++; $display("FAIL midrst_outputs got=%b want=00000", {a_cyc, a_stb, a_we, a_busy, a_done});
      end
      d = 0;
      repeat (10) begin @(negedge clk); if (a_done) d++; end
      total++;
      if (d != 0 || a_dc !== model_dc || a_busy !== 1'b0) begin
         bad++; $display("FAIL midrst_nocount pulses=%0d count=%0d busy=%b want 0/%0d/0", d, a_dc, a_busy, model_dc);
      end
   endtask

   task automatic test_dropped();
      int d, g, gb, w0, n;
      bit to;
      logic [7:0] exp_dp;
      anim_cfg = 700; script_len = 0; wr_stall_cfg = 0;
      w0 = wr_acc;
      trig_a = 1'b1;
      n = 0;
      while (!a_busy && n < 10) begin @(negedge clk); n++; end
      for (int i = 0; i < 301; i++) begin
         trig_a = 1'b0; @(negedge clk);
         trig_a = 1'b1; @(negedge clk);
      end
      repeat (2) @(negedge clk);
      exp_dp = (301 > 255) ? 8'd255 : 8'(301);
      total++;
      if (a_dp !== exp_dp || a_busy !== 1'b1) begin
         bad++; $display("FAIL drop_saturate dropped=%0d busy=%b want %0d/1", a_dp, a_busy, exp_dp);
      end
      trig_a = 1'b0;
      run_until_idle(1500, d, g, gb, to);
      model_dc = model_dc + 8'd1;
      total++;
      if (to || d != 1 || wr_acc - w0 != 1) begin
         bad++; $display("FAIL drop_one_write timed_out=%0d pulses=%0d writes=%0d want 0/1/1", to, d, wr_acc - w0);
      end
      total++;
      if (a_dc !== model_dc) begin bad++; $display("FAIL drop_count got=%0d want=%0d", a_dc, model_dc); end
      anim_cfg = 0;
   endtask

   task automatic test_timeout();
      int n;
      bit seen;
      ack_b_mode = 1'b0; clr_b = 1'b1;
      trig_b = 1'b1;
      n = 0;
      while (!b_cyc && n < 10) begin @(negedge clk); n++; end
      n = 0;
      while (b_cyc && n < 100) begin n++; @(negedge clk); end
      total++;
      if (n != P_TO_B) begin bad++; $display("FAIL to_cycles cyc_high=%0d want=%0d", n, P_TO_B); end
      total++;
      if (b_err !== 1'b1 || b_busy !== 1'b0 || b_stb !== 1'b0) begin
         bad++; $display("FAIL to_err_priority err=%b busy=%b stb=%b want 1/0/0", b_err, b_busy, b_stb);
      end
      clr_b = 1'b0; trig_b = 1'b0;
      @(negedge clk);
      trig_b = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if (b_err !== 1'b1 || b_dp !== 8'd1 || b_cyc !== 1'b0) begin
         bad++; $display("FAIL to_err_drop err=%b dropped=%0d cyc=%b want 1/1/0", b_err, b_dp, b_cyc);
      end
      trig_b = 1'b0; clr_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
      total++;
      if (b_err !== 1'b0) begin bad++; $display("FAIL to_clear err=%b want=0", b_err); end
      ack_b_mode = 1'b1;
      trig_b = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); if (b_done) seen = 1'b1; end
      trig_b = 1'b0;
      total++;
      if (!seen || b_dc !== 8'd1 || b_err !== 1'b0) begin
         bad++; $display("FAIL to_recover done_seen=%b count=%0d err=%b want 1/1/0", seen, b_dc, b_err);
      end
   endtask

   initial begin
      test_reset();
      test_basic_sweep();
      test_write_stall();
      test_poll_gap();
      test_random_sweeps();
      test_reset_mid();
      test_dropped();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
